// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - shares one single-port backend memory between fetch and load/store
// Data access is issued first, fetch second; the pipeline is stalled until both are done.
module unified_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic              if_ready_o,
    input  logic              dm_read_i,
    input  logic              dm_write_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] INST   = 2'd2;
    localparam logic [1:0] COMMIT = 2'd3;

    localparam int               CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    logic [1:0]        state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]  wait_q, wait_d;
    logic [DATA_W-1:0] if_data_q, if_data_d;
    logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
    logic              if_done_q, if_done_d;
    logic              dm_done_q, dm_done_d;
    logic              err_q, err_d;

    logic              dm_pend;
    logic              any_req;
    logic              ack_ok;
    logic              timeout;
    logic              access_done;
    logic [DATA_W-1:0] rdata_eff;

    assign dm_pend     = dm_read_i | dm_write_i;
    assign any_req     = dm_pend | if_req_i;
    assign ack_ok      = mem_req_q & mem_ack_i;
    // An abort behaves like an ack that returns zero data.
    assign timeout     = mem_req_q & ~mem_ack_i & (wait_q == CNT_LAST);
    assign access_done = ack_ok | timeout;
    assign rdata_eff   = timeout ? '0 : mem_rdata_i;

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wait_d      = wait_q;
        if_data_d   = if_data_q;
        dm_rdata_d  = dm_rdata_q;
        if_done_d   = if_done_q;
        dm_done_d   = dm_done_q;
        err_d       = err_q | timeout;

        case (state_q)
            IDLE: begin
                if (dm_pend) begin
                    state_d     = DATA;
                    mem_req_d   = 1'b1;
                    mem_we_d    = dm_write_i;
                    mem_addr_d  = dm_addr_i;
                    mem_wdata_d = dm_wdata_i;
                    wait_d      = '0;
                end else if (if_req_i) begin
                    state_d     = INST;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr_i;
                    mem_wdata_d = '0;
                    wait_d      = '0;
                end
            end
            DATA: begin
                if (access_done) begin
                    dm_done_d = 1'b1;
                    if (!mem_we_q) begin
                        dm_rdata_d = rdata_eff;
                    end
                    if (if_req_i) begin
                        state_d     = INST;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr_i;
                        mem_wdata_d = '0;
                        wait_d      = '0;
                    end else begin
                        state_d   = COMMIT;
                        mem_req_d = 1'b0;
                        mem_we_d  = 1'b0;
                    end
                end else if (mem_req_q) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            INST: begin
                if (access_done) begin
                    if_done_d = 1'b1;
                    if_data_d = rdata_eff;
                    state_d   = COMMIT;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end else if (mem_req_q) begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                if_done_d = 1'b0;
                dm_done_d = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wait_q      <= '0;
            if_data_q   <= '0;
            dm_rdata_q  <= '0;
            if_done_q   <= 1'b0;
            dm_done_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wait_q      <= wait_d;
            if_data_q   <= if_data_d;
            dm_rdata_q  <= dm_rdata_d;
            if_done_q   <= if_done_d;
            dm_done_q   <= dm_done_d;
            err_q       <= err_d;
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign stall_o     = rst_i & any_req & (state_q != COMMIT);
    assign if_ready_o  = (state_q == COMMIT) & if_done_q;
    assign dm_ready_o  = (state_q == COMMIT) & dm_done_q;
    assign if_data_o   = if_data_q;
    assign dm_rdata_o  = dm_rdata_q;
    assign mem_req_o   = mem_req_q;
    assign mem_we_o    = mem_we_q;
    assign mem_addr_o  = mem_addr_q;
    assign mem_wdata_o = mem_wdata_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - randomized self-checking bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

    localparam int TO = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, dm_read, dm_write, mem_ack;
    logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
    logic [31:0] if_data, dm_rdata, mem_addr, mem_wdata;
    logic        if_ready, dm_ready, mem_req, mem_we, stall, err;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_dm_rdata = '0;
    logic [31:0] m_if_data  = '0;
    logic        m_err      = 1'b0;

    always #5 clk = ~clk;

    unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
        .dm_read_i(dm_read), .dm_write_i(dm_write), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_rdata_o(dm_rdata), .dm_ready_o(dm_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .mem_ack_i(mem_ack),
        .stall_o(stall), .err_o(err)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_req"}, mem_req, 0);
        check({tag, "_we"}, mem_we, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_ready"}, {if_ready, dm_ready}, 0);
        check({tag, "_data"}, {if_data, dm_rdata}, 0);
        check({tag, "_err"}, err, 0);
    endtask

    task automatic idle(input int ncyc);
        if_req = 0; dm_read = 0; dm_write = 0;
        for (int c = 0; c < ncyc; c++) begin
            mem_ack   = 1'($urandom_range(0, 1));
            mem_rdata = $urandom;
            #1;
            check("idle_stall", stall, 0);
            check("idle_req", mem_req, 0);
            check("idle_ready", {if_ready, dm_ready}, 0);
            @(posedge clk); #1;
        end
    endtask

    // One pipeline step: each access gets an ack delay in wait cycles (>= TO means no ack).
    task automatic step(input logic dr, input logic dw, input logic ifr,
                        input logic [31:0] daddr, input logic [31:0] wdat, input logic [31:0] iaddr,
                        input int dly_d, input int dly_i,
                        input logic [31:0] rd_d, input logic [31:0] rd_i);
        logic [31:0] e_addr [2];
        logic        e_we   [2];
        logic [31:0] e_wd   [2];
        int          e_dly  [2];
        logic [31:0] e_rd   [2];
        int   n = 0, exp_stall = 0, stall_cnt = 0, idx = 0, acc = 0;
        logic fin, req_prev, committed = 1'b0;

        if (dr | dw) begin
            e_addr[n] = daddr; e_we[n] = dw; e_wd[n] = wdat; e_dly[n] = dly_d; e_rd[n] = rd_d; n++;
        end
        if (ifr) begin
            e_addr[n] = iaddr; e_we[n] = 0; e_wd[n] = 0; e_dly[n] = dly_i; e_rd[n] = rd_i; n++;
        end
        for (int i = 0; i < n; i++) begin
            exp_stall += (e_dly[i] >= TO) ? TO : e_dly[i] + 1;
            if (e_dly[i] >= TO) m_err = 1'b1;
        end
        if (n > 0) exp_stall += 1;
        if ((dr | dw) && !dw) m_dm_rdata = (dly_d >= TO) ? 32'h0 : rd_d;
        if (ifr) m_if_data = (dly_i >= TO) ? 32'h0 : rd_i;

        dm_read = dr; dm_write = dw; if_req = ifr;
        dm_addr = daddr; dm_wdata = wdat; if_addr = iaddr;

        for (int c = 0; c < 200 && !committed; c++) begin
            fin = 1'b0;
            req_prev = mem_req;
            if (mem_req && idx < n) begin
                if (acc == 0 || acc == e_dly[idx] || acc == TO - 1) begin
                    check("mem_addr", mem_addr, e_addr[idx]);
                    check("mem_we", mem_we, e_we[idx]);
                    if (e_we[idx]) check("mem_wdata", mem_wdata, e_wd[idx]);
                end
                mem_ack   = (acc == e_dly[idx]);
                mem_rdata = mem_ack ? e_rd[idx] : $urandom;
                fin       = mem_ack || (acc == TO - 1);
            end else begin
                if (mem_req) check("extra_access", idx, n - 1);
                mem_ack   = 1'($urandom_range(0, 1));
                mem_rdata = $urandom;
            end
            #1;
            if (stall) begin
                stall_cnt++;
                check("ready_in_stall", {if_ready, dm_ready}, 0);
            end else begin
                committed = 1'b1;
                check("stall_cycles", stall_cnt, exp_stall);
                check("if_ready", if_ready, ifr);
                check("dm_ready", dm_ready, dr | dw);
                check("dm_rdata", dm_rdata, m_dm_rdata);
                check("if_data", if_data, m_if_data);
                check("err", err, m_err);
                check("req_at_commit", mem_req, 0);
                check("access_count", idx, n);
            end
            @(posedge clk); #1;
            if (fin) begin
                idx++; acc = 0;
            end else if (req_prev) begin
                acc++;
            end
        end
        if (!committed) check("commit_reached", 0, 1);
        dm_read = 0; dm_write = 0; if_req = 0;
    endtask

    function automatic int rand_delay();
        int r;
        r = $urandom_range(0, 9);
        if (r < 6) return $urandom_range(0, 3);
        if (r == 6) return TO - 1;
        if (r == 7) return TO;
        return NEVER;
    endfunction

    initial begin
        rst_n = 0; if_req = 0; dm_read = 0; dm_write = 0; mem_ack = 0;
        if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        idle(10);
        step(0, 0, 1, 32'h0, 32'h0, 32'h10, 0, 2, 32'h0, 32'h8C010004);
        step(1, 0, 1, 32'h20, 32'h0, 32'h14, 0, 0, 32'hAAAA5555, 32'h00000020);
        step(0, 1, 0, 32'h40, 32'hDEADBEEF, 32'h0, 3, 0, 32'h12345678, 32'h0);
        step(1, 1, 1, 32'h44, 32'hCAFEF00D, 32'h18, 1, 1, 32'h11111111, 32'h22222222);
        step(1, 0, 0, 32'h48, 32'h0, 32'h0, TO - 1, 0, 32'h0BADCAFE, 32'h0);
        check("err_before_timeout", err, 0);
        step(1, 0, 0, 32'h4C, 32'h0, 32'h0, NEVER, 0, 32'h55555555, 32'h0);
        step(1, 0, 1, 32'h50, 32'h0, 32'h1C, NEVER, 1, 32'h66666666, 32'h77777777);
        idle(3);
        check("err_sticky", err, 1);

        for (int s = 0; s < 40; s++) begin
            logic dr, dw, ifr;
            dr  = 1'($urandom_range(0, 1));
            dw  = ($urandom_range(0, 3) == 0);
            ifr = 1'($urandom_range(0, 1));
            step(dr, dw, ifr, $urandom, $urandom, $urandom, rand_delay(), rand_delay(),
                 $urandom, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end

        dm_read = 1; dm_addr = 32'h80; mem_ack = 0;
        @(posedge clk); #1;
        check("pre_reset_req", mem_req, 1);
        rst_n = 0;
        #1;
        check_all_zero("async_reset");
        m_err = 0; m_dm_rdata = 0; m_if_data = 0;
        dm_read = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;
        idle(10);
        step(1, 0, 1, 32'h90, 32'h0, 32'h94, 1, 0, 32'h31415926, 32'h27182818);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/unified_mem_arbiter.md
Name: unified_mem_arbiter

Overview:
- Shares one single-port backend memory between the IF-stage instruction fetch and the MEM-stage load/store of the 5-stage pipeline.
- Sequences the accesses within one pipeline step, data first and fetch second.
- Holds the pipeline with stall_o until every pending access has been acknowledged, then releases it for exactly one cycle.
- Tolerates variable backend latency, with a watchdog timeout.

Parameters:
- ADDR_W, 32, address width of all address ports.
- DATA_W, 32, data width of all data ports.
- TIMEOUT_CYC, 255, maximum cycles mem_req_o may wait for mem_ack_i before the access is aborted.

Ports:
- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- if_req_i  in  1  IF stage requests an instruction read.
- if_addr_i  in  ADDR_W  fetch address (PC).
- if_data_o  out  DATA_W  latched instruction word.
- if_ready_o  out  1  one-cycle pulse: if_data_o valid for this step.
- dm_read_i  in  1  MEM stage load request.
- dm_write_i  in  1  MEM stage store request.
- dm_addr_i  in  ADDR_W  load/store address.
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  latched load data.
- dm_ready_o  out  1  one-cycle pulse: data access complete.
- mem_req_o  out  1  backend request, registered.
- mem_we_o  out  1  backend write enable.
- mem_addr_o  out  ADDR_W  backend address.
- mem_wdata_o  out  DATA_W  backend write data.
- mem_rdata_i  in  DATA_W  backend read data, valid with mem_ack_i.
- mem_ack_i  in  1  backend completion; meaningful only while mem_req_o=1.
- stall_o  out  1  freeze PC, IF/ID, ID/EX, EX/MEM, MEM/WB.
- err_o  out  1  sticky timeout flag.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE. All outputs 0, including mem_req_o, which drops immediately. Counters and done flags cleared.
- States: IDLE, DATA, INST, COMMIT.
- Pending request: dm_pend = dm_read_i|dm_write_i; any_req = dm_pend|if_req_i.
- stall_o (combinational) = any_req && state!=COMMIT. It asserts in the same cycle the requests appear.
- IDLE:
  - dm_pend -> DATA.
  - else if_req_i -> INST.
  - else stay in IDLE.
  - On entry to DATA/INST, register mem_req_o=1 with addr/we/wdata.
- Request hold: mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o stay constant until the cycle mem_ack_i=1 is sampled. mem_req_o deasserts the cycle after that.
- DATA:
  - mem_we_o = dm_write_i.
  - If dm_read_i and dm_write_i are both high, the write wins and dm_rdata_o is left unchanged.
  - On ack: for a read, latch mem_rdata_i into dm_rdata_o. Set dm_done.
  - Next state: INST if if_req_i, else COMMIT. Back-to-back issue is allowed: mem_req_o stays high into INST with the new address.
- INST: mem_we_o=0. On ack, latch if_data_o and go to COMMIT.
- COMMIT:
  - Lasts one cycle. stall_o=0, so the pipeline advances.
  - if_ready_o/dm_ready_o pulse high for each access done this step.
  - Done flags clear; next state IDLE.
- Latency, with ack in the first cycle mem_req_o is high:
  - single access: 3 cycles from request to COMMIT.
  - fetch plus data access: 4 cycles.
  - Each extra wait cycle of the backend adds 1.
- Input stability: requester inputs are held stable by the pipeline while stall_o=1. The arbiter samples them once, on DATA/INST entry.
- Timeout:
  - A wait counter resets on every new issue and increments while mem_req_o=1 && !mem_ack_i.
  - On reaching TIMEOUT_CYC: the access is aborted, mem_req_o drops, the read result is forced to 0, err_o is set, and sequencing continues as if acked.
  - err_o clears only on reset.
- An ack arriving while mem_req_o=0 is ignored.

Test Plan:
- Fetch only: if_req_i=1, if_addr_i=0x10, ack 2 cycles after mem_req_o, mem_rdata_i=0x8C010004 -> mem_addr_o=0x10, mem_we_o=0, stall_o high for 4 cycles, COMMIT with if_ready_o=1, if_data_o=0x8C010004.
- Load plus fetch: dm_read_i=1, dm_addr_i=0x20, if_addr_i=0x14, immediate acks with data 0xAAAA5555 then 0x00000020 -> mem_addr_o sequence 0x20 then 0x14. dm_rdata_o=0xAAAA5555, if_data_o=0x00000020, both ready pulses in the same cycle, stall_o low exactly 1 cycle.
- Store: dm_write_i=1, dm_addr_i=0x40, dm_wdata_i=0xDEADBEEF -> mem_we_o=1, mem_wdata_o=0xDEADBEEF held until ack, dm_rdata_o unchanged.
- Timeout with TIMEOUT_CYC=8 and no ack -> mem_req_o drops after 8 waiting cycles, err_o=1 and stays 1, dm_rdata_o=0, COMMIT follows.
- Reset mid-access: rst_i low while mem_req_o=1 -> all outputs 0 asynchronously. After release with no requests: stall_o=0, mem_req_o=0.
- Idle: no requests for 10 cycles -> stall_o=0, mem_req_o=0, no ready pulses.
